// File: rtl/fft_pkg.sv
// Shared FFT front-end definitions.
// Frame-size defaults and sequencer state encoding.
package fft_pkg;

    localparam int LOG2N_DEF = 7;
    localparam int N_DEF     = 1 << LOG2N_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/bitrev_addr.sv
// Pure combinational bit reversal of an address.
// Bit k of the output is bit LOG2N-1-k of the input.
module bitrev_addr #(
    parameter int LOG2N = 7
) (
    input  logic [LOG2N-1:0] i_addr,
    output logic [LOG2N-1:0] o_addr
);

    genvar g;
    for (g = 0; g < LOG2N; g++) begin : g_rev
        assign o_addr[g] = i_addr[LOG2N-1-g];
    end

endmodule

// File: rtl/bitrev_sequencer.sv
// Bit-reversal reorder sequencer over an external frame buffer.
// Writes land at reversed addresses; reads drain in natural order.
module bitrev_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [LOG2N-1:0] mem_waddr,
    output logic [DW-1:0]    mem_wdata,
    output logic             mem_re,
    output logic [LOG2N-1:0] mem_raddr,
    input  logic [DW-1:0]    mem_rdata,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N:0]   N_CNT     = (LOG2N+1)'(N);
    localparam logic [LOG2N-1:0] LAST_ADDR = LOG2N'(N - 1);

    state_t           r_state;
    logic [LOG2N:0]   r_wcnt;
    logic [LOG2N:0]   r_rcnt;
    logic             r_inflight;
    logic             r_inflight_last;
    logic [DW-1:0]    r_fifo_data [2];
    logic [1:0]       r_fifo_last;
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_occ;

    logic             w_in_hs;
    logic             w_out_hs;
    logic [1:0]       w_pend;
    logic [LOG2N-1:0] w_waddr;

    bitrev_addr #(
        .LOG2N (LOG2N)
    ) u_rev (
        .i_addr (r_wcnt[LOG2N-1:0]),
        .o_addr (w_waddr)
    );

    assign in_ready  = (r_state == ST_LOAD);
    assign busy      = (r_state != ST_IDLE);
    assign w_in_hs   = in_valid && in_ready;

    assign mem_we    = w_in_hs;
    assign mem_waddr = w_waddr;
    assign mem_wdata = in_data;

    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_fifo_data[r_rd_ptr];
    assign out_last   = out_valid && r_fifo_last[r_rd_ptr];
    assign w_out_hs   = out_valid && out_ready;
    assign frame_done = w_out_hs && out_last;

    // Entries held after this cycle's pop plus the read in flight;
    // counting the pop lets a steady stream issue one read per cycle.
    assign w_pend    = r_occ - {1'b0, w_out_hs} + {1'b0, r_inflight};
    assign mem_re    = (r_state == ST_DRAIN) && (w_pend < 2'd2)
                       && !r_rcnt[LOG2N];
    assign mem_raddr = r_rcnt[LOG2N-1:0];

    // Frame sequencing: load N samples, then drain until last handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_wcnt  <= '0;
                        r_rcnt  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_in_hs) begin
                        r_wcnt <= r_wcnt + 1'b1;
                        if (r_wcnt == N_CNT - 1'b1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mem_re) begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                    if (frame_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read tracking and FIFO pointers/occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_last     <= '0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_occ           <= 2'd0;
        end else begin
            r_inflight      <= mem_re;
            r_inflight_last <= mem_re && (r_rcnt[LOG2N-1:0] == LAST_ADDR);
            if (r_inflight) begin
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_out_hs) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_out_hs};
        end
    end

    // FIFO payload capture; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_bitrev_sequencer.sv
// Self-checking bench for bitrev_sequencer.
// Scoreboard holds each frame's expected reordered output stream.
module tb_bitrev_sequencer;

    localparam int LOG2N = 7;
    localparam int N     = 1 << LOG2N;
    localparam int DW    = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic             in_ready;
    logic             mem_we;
    logic [LOG2N-1:0] mem_waddr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_re;
    logic [LOG2N-1:0] mem_raddr;
    logic [DW-1:0]    mem_rdata = '0;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             frame_done;

    bitrev_sequencer #(
        .LOG2N (LOG2N),
        .DW    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural frame buffer with one-cycle read latency.
    logic [DW-1:0] ram [N];
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_raddr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        int x = k;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    int  exp_q[$];
    int  cur_base = 0;
    int  w_idx = 0;
    int  r_idx = 0;
    int  pop_idx = 0;
    int  outstanding = 0;
    int  done_cnt = 0;
    int  cyc = 0;
    int  first_re = 0;
    int  span = 0;
    bit  tb_load = 0;
    bit  tb_drain = 0;
    bit  mon_en = 0;
    bit  prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    bit  cap_on = 0;
    int  cap_w[4];
    int  cap_o[4];
    int  cap_last = -1;

    // Single compare process: every negedge, outputs vs. model.
    always @(negedge clk) begin
        int  e;
        bit  hs;
        cyc++;
        if (mon_en) begin
            hs = out_valid && out_ready;
            if (!tb_load) chk("no_write_outside_load", mem_we, 0);
            if (!tb_drain) chk("no_read_outside_drain", mem_re, 0);
            if (mem_we && tb_load) begin
                chk("waddr", mem_waddr, rev(w_idx));
                chk("wdata", mem_wdata, cur_base + w_idx);
                if (cap_on && w_idx < 4) cap_w[w_idx] = int'(mem_waddr);
                w_idx++;
                if (w_idx == N) begin
                    tb_load = 0;
                    tb_drain = 1;
                end
            end
            if (mem_re && tb_drain) begin
                if (r_idx == 0) first_re = cyc;
                chk("raddr", mem_raddr, r_idx);
                r_idx++;
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (hs) begin
                chk("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                    chk("out_last", out_last, pop_idx == N - 1);
                    chk("frame_done", frame_done, pop_idx == N - 1);
                    if (cap_on && pop_idx < 4) cap_o[pop_idx] = int'(out_data);
                    if (cap_on && pop_idx == N - 1) cap_last = int'(out_data);
                    pop_idx++;
                    if (pop_idx == N) begin
                        done_cnt++;
                        span = cyc - first_re;
                        tb_drain = 0;
                    end
                end
            end else begin
                chk("frame_done_no_hs", frame_done, 0);
            end
            outstanding = outstanding + int'(mem_re) - int'(hs);
            if (mem_re) chk("outstanding_le2", outstanding <= 2, 1);
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic chk_idle(input string name);
        chk(name, {busy, in_ready, mem_we, mem_re, out_valid,
                   out_last, frame_done}, 0);
    endtask

    // Reset held with start high: reset must win.
    task automatic reset_dut();
        mon_en = 0;
        rst = 0;
        start = 1;
        in_valid = 0;
        out_ready = 0;
        #1;
        chk_idle("idle_in_reset");
        repeat (2) @(posedge clk);
        #1;
        chk_idle("idle_reset_with_start");
        start = 0;
        rst = 1;
        exp_q.delete();
        w_idx = 0;
        r_idx = 0;
        pop_idx = 0;
        outstanding = 0;
        done_cnt = 0;
        tb_load = 0;
        tb_drain = 0;
        prev_stall = 0;
        mon_en = 1;
        @(posedge clk);
        #1;
        chk("busy_after_reset", busy, 0);
    endtask

    task automatic start_frame(input int base);
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(base + rev(k));
        cur_base = base;
        w_idx = 0;
        r_idx = 0;
        pop_idx = 0;
        done_cnt = 0;
        outstanding = 0;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        tb_load = 1;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic load(input bit gaps, input int start_at,
                        input int abort_at, output bit aborted);
        aborted = 0;
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                reset_dut();
                aborted = 1;
                return;
            end
            if (gaps) begin
                in_valid = 0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1;
            in_data = DW'(cur_base + i);
            start = (i == start_at);
            @(posedge clk);
            #1;
            start = 0;
        end
        in_valid = 0;
        chk("in_ready_low_after_load", in_ready, 0);
        chk("write_count", w_idx, N);
    endtask

    task automatic drain(input int mode, input int start_at,
                         input int abort_after);
        int n = 0;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (done_cnt == 0 && n < 4000) begin
            if (n == abort_after) begin
                reset_dut();
                return;
            end
            case (mode)
                0: out_ready = 1;
                1: out_ready = pat[n % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = (n == start_at);
            in_valid = (n == start_at + 1);
            @(posedge clk);
            #1;
            start = 0;
            in_valid = 0;
            n++;
        end
        chk("drain_completed", done_cnt, 1);
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("frame_done_once", done_cnt, 1);
        chk("idle_after_frame", busy, 0);
        chk("all_outputs_seen", exp_q.size(), 0);
        if (mode == 0) chk("drain_span", span, N + 1);
    endtask

    initial begin
        bit ab;
        int lit[4] = '{0, 64, 32, 96};

        reset_dut();

        // in_valid while idle must be ignored
        in_valid = 1;
        in_data = 32'hdead;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 0;
        chk("idle_in_valid_ignored", busy, 0);

        // Frame A: data=i, no gaps, stray starts in load and drain
        cap_on = 1;
        start_frame(0);
        load(0, 10, -1, ab);
        drain(0, 5, -1);
        cap_on = 0;
        for (int k = 0; k < 4; k++) begin
            chk("lit_waddr", cap_w[k], lit[k]);
            chk("lit_out", cap_o[k], lit[k]);
        end
        chk("lit_last", cap_last, 127);

        // Frame B: input gaps, out_ready 1,0,0,1 pattern
        start_frame(32'h1000);
        load(1, -1, -1, ab);
        drain(1, -1, -1);

        // Frame C: reset at input sample 50
        start_frame(32'h2000);
        load(0, -1, 50, ab);
        chk("aborted_load", ab, 1);
        repeat (5) @(posedge clk);
        #1;
        chk_idle("idle_after_load_abort");

        // Frame D: clean frame, random out_ready
        start_frame(32'h3000);
        load(0, -1, -1, ab);
        drain(2, -1, -1);

        // Frame E: reset mid-drain
        start_frame(32'h4000);
        load(0, -1, -1, ab);
        drain(2, -1, 20);
        repeat (5) @(posedge clk);
        #1;
        chk_idle("idle_after_drain_abort");

        // Frame F: full-rate clean frame after aborts
        start_frame(0);
        load(0, -1, -1, ab);
        drain(0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
